// File: rtl/cosim_cycle_pkg.sv
// cosim_cycle_pkg: response layout, width and type ID for the cosim cycle-count service (COSIM_CYCLE_SNAPSHOT_DELTA_EN adds delta)
package cosim_cycle_pkg;
`ifdef COSIM_CYCLE_SNAPSHOT_DELTA_EN
  typedef struct packed {
    logic [63:0] cycle;
    logic [63:0] freq;
    logic [63:0] delta;
  } resp_t;
  localparam string TYPE_ID = "struct{cycle:int<64>,freq:int<64>,delta:int<64>}";
`else
  typedef struct packed {
    logic [63:0] cycle;
    logic [63:0] freq;
  } resp_t;
  localparam string TYPE_ID = "struct{cycle:int<64>,freq:int<64>}";
`endif
  localparam int RESP_W = $bits(resp_t);
endpackage

// File: rtl/cosim_sync_fifo.sv
// cosim_sync_fifo: generic synchronous FIFO with occupancy count, no bypass
module cosim_sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rp];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/cosim_cycle_snapshot.sv
// cosim_cycle_snapshot: samples cycle_count on request accept and queues responses
// Optional delta field enabled by COSIM_CYCLE_SNAPSHOT_DELTA_EN.
module cosim_cycle_snapshot
  import cosim_cycle_pkg::*;
#(
  parameter longint unsigned CORE_CLOCK_FREQUENCY_HZ = 100_000_000,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [63:0]                cycle_count,
  input  logic                       req_valid,
  output logic                       req_ready,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [RESP_W-1:0]          resp_data,
  output logic [$clog2(DEPTH+1)-1:0] outstanding
);
  logic init_done, full, empty, accept;
  resp_t entry;
  assign accept = req_valid && req_ready;
  assign req_ready = init_done && !full;
  assign resp_valid = !empty;
  always_ff @(posedge clk or negedge rst)
    if (!rst) init_done <= 1'b0;
    else init_done <= 1'b1;
`ifdef COSIM_CYCLE_SNAPSHOT_DELTA_EN
  logic [63:0] last_sample;
  logic first;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      last_sample <= '0;
      first <= 1'b1;
    end else if (accept) begin
      last_sample <= cycle_count;
      first <= 1'b0;
    end
  // wrap-safe: unsigned 64-bit subtraction is modulo 2^64
  assign entry = '{cycle: cycle_count, freq: CORE_CLOCK_FREQUENCY_HZ,
                   delta: first ? 64'd0 : cycle_count - last_sample};
`else
  assign entry = '{cycle: cycle_count, freq: CORE_CLOCK_FREQUENCY_HZ};
`endif
  cosim_sync_fifo #(.W(RESP_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(accept),
    .pop(resp_ready),
    .wdata(entry),
    .rdata(resp_data),
    .full(full),
    .empty(empty),
    .count(outstanding)
  );
endmodule

// File: tb/tb_cosim_cycle_snapshot.sv
// tb_cosim_cycle_snapshot: directed and random checks against a queue-based response model
module tb_cosim_cycle_snapshot;
  import cosim_cycle_pkg::*;
  localparam int DEPTH = 4;
  localparam logic [63:0] FREQ = 64'd100_000_000;
  logic clk, rst, req_valid, req_ready, resp_valid, resp_ready;
  logic [63:0] cycle_count;
  logic [RESP_W-1:0] resp_data;
  logic [$clog2(DEPTH+1)-1:0] outstanding;
  int n_checks, n_fail;
  logic [191:0] q [$];
  logic [63:0] last_m, cnt;
  logic [RESP_W-1:0] held;
  bit first_m, init_m;

  cosim_cycle_snapshot #(.CORE_CLOCK_FREQUENCY_HZ(100_000_000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cycle_count(cycle_count), .req_valid(req_valid),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .outstanding(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_outstanding"}, outstanding, 0);
  endtask

  task automatic model_clear();
    q.delete();
    init_m = 0;
    first_m = 1;
    last_m = '0;
  endtask

  // one cycle: drive after negedge, compare against the model, then advance the model at posedge
  task automatic step(input logic rv, input logic rr, input logic [63:0] cc);
    logic acc, pp;
    logic [191:0] head;
    @(negedge clk);
    req_valid = rv;
    resp_ready = rr;
    cycle_count = cc;
    #1;
    check("req_ready", req_ready, init_m && q.size() != DEPTH);
    check("resp_valid", resp_valid, q.size() != 0);
    check("outstanding", outstanding, q.size());
    if (q.size() != 0) begin
      head = q[0];
      check("resp_data", resp_data, head[191 -: RESP_W]);
    end
    acc = rv && init_m && q.size() != DEPTH;
    pp = rr && q.size() != 0;
    @(posedge clk);
    if (pp) void'(q.pop_front());
    if (acc) begin
      q.push_back({cc, FREQ, first_m ? 64'd0 : cc - last_m});
      last_m = cc;
      first_m = 0;
    end
    init_m = 1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    model_clear();
    #1;
    check_idle("reset_async");
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_hold");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("release_not_ready", req_ready, 0);
    @(posedge clk);
    init_m = 1;
    #1;
    check("release_ready", req_ready, 1);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    cycle_count = '0;
    do_reset();

    step(1, 1, 64'h10);
    #2;
    check("single_valid", resp_valid, 1);
    check("single_cycle", resp_data[RESP_W-1 -: 64], 64'h10);
    check("single_freq", resp_data[RESP_W-65 -: 64], 64'd100_000_000);
`ifdef COSIM_CYCLE_SNAPSHOT_DELTA_EN
    check("single_delta", resp_data[63:0], 0);
`endif
    step(0, 1, 64'h11);
    step(0, 0, 64'h12);

    for (int i = 0; i < 5; i++) step(1, 0, 64'(20 + i));
    #2;
    check("fill_outstanding", outstanding, DEPTH);
    check("fill_not_ready", req_ready, 0);
    held = resp_data;
    step(0, 0, 64'd25);
    #2;
    check("stall_stable", resp_data, held);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 64'(26 + i));
      #2;
      if (i < 3) check("drain_order", resp_data[RESP_W-1 -: 64], 64'(21 + i));
    end
    step(0, 0, 64'd30);

    step(1, 0, 64'hFFFF_FFFF_FFFF_FFFE);
    step(1, 0, 64'h3);
    step(0, 1, 64'h4);
    #2;
    check("wrap_cycle", resp_data[RESP_W-1 -: 64], 64'h3);
`ifdef COSIM_CYCLE_SNAPSHOT_DELTA_EN
    check("wrap_delta", resp_data[63:0], 5);
`endif
    step(0, 1, 64'h5);

    step(1, 0, 64'h100);
    step(1, 0, 64'h101);
    step(1, 1, 64'h102);
    #2;
    check("simul_outstanding", outstanding, 2);
    check("simul_head", resp_data[RESP_W-1 -: 64], 64'h101);
    step(0, 1, 64'h103);
    step(0, 1, 64'h104);
    step(0, 0, 64'h105);

    cnt = 64'hFFFF_FFFF_FFFF_FFF0;
    for (int i = 0; i < 300; i++) begin
      cnt = cnt + 64'($urandom_range(1, 3));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0 || i >= 250), cnt);
    end

    step(1, 0, 64'h200);
    step(1, 0, 64'h201);
    step(1, 0, 64'h202);
    #3;
    rst = 1'b0;
    #1;
    check("async_resp_valid", resp_valid, 0);
    check("async_outstanding", outstanding, 0);
    check("async_req_ready", req_ready, 0);
    do_reset();
    step(0, 1, 64'h300);
    step(1, 1, 64'h301);
    step(0, 1, 64'h302);
    step(0, 1, 64'h303);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cosim_cycle_snapshot.md
# cosim_cycle_snapshot

Request-side stage for the cosim cycle-count service. It sits between the host request channel and the to-host response endpoint and consumes the design's free-running 64-bit cycle counter. On each accepted host request it captures the counter value in that exact cycle, so queuing does not skew the result. It then queues up to DEPTH `{cycle, freq[, delta]}` responses while the response channel is back-pressured.

## Interface
Parameters:
- CORE_CLOCK_FREQUENCY_HZ, 100_000_000: longint unsigned; copied into every response's `freq` field.
- DEPTH, 4: response queue entries; power of two, ≥2.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- cycle_count  in  64  free-running cycle counter, sampled on request accept.
- req_valid  in  1  host request (0-bit payload).
- req_ready  out  1  request accepted when req_valid && req_ready.
- resp_valid  out  1  head response valid.
- resp_ready  in  1  response endpoint ready.
- resp_data  out  RESP_W  packed response; RESP_W is 128, or 192 with delta (see Configuration).
- outstanding  out  $clog2(DEPTH+1)  current queue occupancy.

## Operation
- Accept = req_valid && req_ready. Pop = resp_valid && resp_ready.
- On accept: push entry {cycle = cycle_count (same cycle), freq = CORE_CLOCK_FREQUENCY_HZ}.
  - With delta enabled: delta = cycle_count − last_sample, modulo 2^64.
  - delta = 0 for the first accept after reset.
  - last_sample ← cycle_count.
- req_ready = init_done && (outstanding != DEPTH). No bypass: a full queue blocks accept even when pop occurs in the same cycle.
- resp_valid = (outstanding != 0). resp_data = queue head, driven from storage.
- Simultaneous accept and pop (not full, not empty): occupancy unchanged, both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is tracked in a separate counter.
- Handshake rules:
  - Once resp_valid is asserted, resp_data holds stable until pop.
  - resp_valid never deasserts without a pop.
- `cycle_count` wrap from 2^64−1 to 0: captured verbatim. delta stays correct modulo 2^64.

## Timing
- Reset (rst low, async) clears:
  - init_done = 0, so req_ready = 0 during reset.
  - pointers and occupancy = 0, so resp_valid = 0 and outstanding = 0.
  - last_sample = 0, first flag = 1.
  - resp_data is don't-care while resp_valid = 0.
- init_done goes to 1 on the first rising clk after rst deasserts. req_ready rises in that same cycle.
- Latency: an accept in cycle N gives resp_valid = 1 in cycle N+1 (queue empty), carrying cycle_count from cycle N.
- Throughput: one accept and one pop per cycle.
- Reset mid-operation: all queued entries are discarded immediately. No partial responses are emitted.

## Configuration
- COSIM_CYCLE_SNAPSHOT_DELTA_EN defined:
  - RESP_W = 192, layout {cycle[191:128], freq[127:64], delta[63:0]}.
  - Type ID string "struct{cycle:int<64>,freq:int<64>,delta:int<64>}".
  - last_sample register and first flag are present.
- Undefined:
  - RESP_W = 128, layout {cycle[127:64], freq[63:0]}.
  - Type ID "struct{cycle:int<64>,freq:int<64>}".
  - No delta logic.

## Structure
- Package cosim_cycle_pkg holds:
  - response struct typedef (both variants under the macro);
  - RESP_W;
  - type ID string constant.
- Sub-module cosim_sync_fifo: generic width/depth FIFO with occupancy output, async active-low reset, no bypass. This block instantiates it once and adds the init, sampling and delta logic.

## Test plan
- Reset release:
  - hold rst low 3 cycles → req_ready = 0, resp_valid = 0, outstanding = 0;
  - first clk after release → req_ready = 1.
- Single request:
  - req_valid pulse with cycle_count = 0x10, resp_ready = 1 → next cycle resp_valid = 1, cycle = 0x10, freq = 100_000_000, delta = 0;
  - popped that cycle.
- Back-pressure fill:
  - resp_ready = 0, 5 consecutive requests at counts 20..24, DEPTH = 4 → 4 accepted, req_ready = 0 at count 24, outstanding = 4;
  - release resp_ready → cycles 20, 21, 22, 23 emitted in order, data stable while stalled.
- Delta and wrap (macro on): requests at counts 0xFFFF_FFFF_FFFF_FFFE then 0x3 → second delta = 5.
- Simultaneous accept and pop at occupancy 2 → outstanding stays 2, order preserved.
- Async reset with 3 entries queued → resp_valid drops immediately, without waiting for clk; no stale entry after release.
